// File: rtl/bus_sequencer.sv
// Purpose : control sequencer for a tri-state register bus with an A/G ALU pair.
// Latency : Done 1 cycle after Go is sampled (LOAD, COPY, illegal), 3 cycles for ADD/SUB.
// Backpr. : none; Go is only accepted in IDLE and ignored while Busy, so the issuer must wait.
//
// Ports
//   CLKb        clock; all state updates on the falling edge
//   Rstb        synchronous active-low reset, sampled on the falling edge
//   Go, Instr   instruction strobe and word: [9:6] opcode, [5:4] reserved, [3:2] Rx, [1:0] Ry
//   Rin, Rout   one-hot load / bus-drive enables for R0..R3
//   ExtOut      external data onto the bus
//   Ain, Gin    load ALU operand A / result G
//   Gout        G onto the bus
//   AddSub      0 = add, 1 = subtract (driven only while Gin is high)
//   Busy, Done, Illegal, InstrCount  status

module bus_sequencer (
    input  logic       CLKb,
    input  logic       Rstb,
    input  logic       Go,
    input  logic [9:0] Instr,
    output logic [3:0] Rin,
    output logic [3:0] Rout,
    output logic       ExtOut,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       AddSub,
    output logic       Busy,
    output logic       Done,
    output logic       Illegal,
    output logic [7:0] InstrCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] T1   = 2'd1;
    localparam logic [1:0] T2   = 2'd2;
    localparam logic [1:0] T3   = 2'd3;

    localparam logic [3:0] OP_LOAD = 4'h0;
    localparam logic [3:0] OP_COPY = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;

    logic [1:0] state;
    logic [1:0] state_nxt;

    // Only the fields that steer the sequence are held; the reserved bits are dropped.
    logic [3:0] opcode_q;
    logic [1:0] rx_q;
    logic [1:0] ry_q;

    logic [3:0] rx_oh;
    logic [3:0] ry_oh;
    logic       is_arith;
    logic       unused_rsvd;

    assign unused_rsvd = ^Instr[5:4];

    assign rx_oh    = 4'b0001 << rx_q;
    assign ry_oh    = 4'b0001 << ry_q;
    assign is_arith = (opcode_q == OP_ADD) || (opcode_q == OP_SUB);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = Go ? T1 : IDLE;
            T1:      state_nxt = is_arith ? T2 : IDLE;
            T2:      state_nxt = T3;
            T3:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(negedge CLKb) begin
        if (!Rstb) begin
            state      <= IDLE;
            opcode_q   <= '0;
            rx_q       <= '0;
            ry_q       <= '0;
            InstrCount <= '0;
        end else begin
            state <= state_nxt;
            // Instr is captured only on acceptance, so later changes cannot disturb the sequence.
            if (state == IDLE && Go) begin
                opcode_q <= Instr[9:6];
                rx_q     <= Instr[3:2];
                ry_q     <= Instr[1:0];
            end
            // Illegal opcodes also finish with Done, so they are counted too; wraps at 255.
            if (Done) begin
                InstrCount <= InstrCount + 8'd1;
            end
        end
    end

    // Every output is a pure function of state and the held instruction, so IDLE
    // (and therefore reset) forces all of them low.
    always_comb begin
        Rin     = '0;
        Rout    = '0;
        ExtOut  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        Illegal = 1'b0;
        Busy    = (state != IDLE);
        case (state)
            T1: begin
                case (opcode_q)
                    OP_LOAD: begin
                        ExtOut = 1'b1;
                        Rin    = rx_oh;
                        Done   = 1'b1;
                    end
                    OP_COPY: begin
                        // Rx == Ry reloads a register from itself: harmless.
                        Rout = ry_oh;
                        Rin  = rx_oh;
                        Done = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout = rx_oh;
                        Ain  = 1'b1;
                    end
                    default: begin
                        Done    = 1'b1;
                        Illegal = 1'b1;
                    end
                endcase
            end
            T2: begin
                Rout   = ry_oh;
                Gin    = 1'b1;
                AddSub = opcode_q[0];
            end
            T3: begin
                Gout = 1'b1;
                Rin  = rx_oh;
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameters: none; bus width (10), register count (4) and opcode width (4) SHALL be fixed.
REQ-002 CLKb  in  1  clock; all state SHALL update on the falling edge of CLKb.
REQ-003 Rstb  in  1  synchronous, active-low reset, sampled on the falling edge of CLKb.
REQ-004 Go  in  1  instruction strobe; qualifies Instr.
REQ-005 Instr  in  10  [9:6] opcode, [5:4] reserved (ignored), [3:2] Rx (destination), [1:0] Ry (source).
REQ-006 Rin  out  4  one-hot load enables for the tri-state registers R0..R3.
REQ-007 Rout  out  4  one-hot bus-drive enables for R0..R3.
REQ-008 ExtOut  out  1  drive external data onto the shared bus.
REQ-009 Ain  out  1  load ALU operand register A from the bus.
REQ-010 Gin  out  1  load ALU result register G.
REQ-011 Gout  out  1  drive G onto the bus.
REQ-012 AddSub  out  1  ALU operation: 0 = add, 1 = subtract; meaningful only while Gin=1.
REQ-013 Busy  out  1  high whenever the state is not IDLE.
REQ-014 Done  out  1  one-cycle pulse in the final step of each instruction.
REQ-015 Illegal  out  1  one-cycle pulse, coincident with Done, for an unsupported opcode.
REQ-016 InstrCount  out  8  number of completed instructions, including illegal ones.

Function
REQ-017 States SHALL be IDLE, T1, T2, T3; all outputs except InstrCount SHALL be decoded combinationally from the state and the latched instruction.
REQ-018 In IDLE with Go=1, the block SHALL latch Instr and move to T1 on the next edge.
REQ-019 Go SHALL be ignored in every state other than IDLE, including the Done cycle; at least one IDLE cycle therefore separates instructions.
REQ-020 Opcode 0000, LOAD: in T1, ExtOut=1, Rin[Rx]=1, Done=1; next state IDLE.
REQ-021 Opcode 0001, COPY: in T1, Rout[Ry]=1, Rin[Rx]=1, Done=1; next state IDLE; Rx==Ry SHALL be legal (no change to the register).
REQ-022 Opcodes 0010 (ADD) and 0011 (SUB) SHALL step as follows:
- T1: Rout[Rx]=1, Ain=1.
- T2: Rout[Ry]=1, Gin=1, AddSub=opcode[0].
- T3: Gout=1, Rin[Rx]=1, Done=1; next state IDLE.
REQ-023 Any other opcode: in T1, Done=1 and Illegal=1, with no Rin, Rout, ExtOut, Ain, Gin or Gout; next state IDLE.
REQ-024 Latency from the edge that samples Go to the Done cycle SHALL be 1 cycle for LOAD, COPY and illegal opcodes, and 3 cycles for ADD and SUB.
REQ-025 Bus exclusivity invariant: in every cycle, at most one of Rout[3:0], ExtOut and Gout SHALL be 1.
REQ-026 At most one Rin bit SHALL be 1 in any cycle.
REQ-027 No Rin bit SHALL be 1 in a cycle without a bus driver.
REQ-028 In IDLE, every enable output, Done and Illegal SHALL be 0.
REQ-029 InstrCount SHALL increment by 1 on the edge ending each Done cycle.
REQ-030 InstrCount SHALL wrap from 255 to 0 without saturating or flagging.
REQ-031 Changes to Instr while Busy=1 SHALL NOT affect the instruction in progress.

Reset
REQ-032 With Rstb=0 at a falling edge, the state SHALL become IDLE, InstrCount 0 and the latched instruction 0.
REQ-033 All outputs SHALL be 0 from that edge onward.
REQ-034 Reset SHALL take priority over Go and over any in-progress step.
REQ-035 Reset asserted mid-instruction SHALL abort it: no further Rin, and no Done for the aborted instruction.
REQ-036 After Rstb returns to 1, the first Go SHALL be accepted on the next edge.

Verification
REQ-037 Instr=0000_00_10_00, Go for 1 cycle -> next cycle ExtOut=1, Rin=0100, Done=1, Busy=1; then IDLE, InstrCount=1.
REQ-038 Instr=0010_00_01_11 (ADD R1,R3):
- T1: Rout=0010, Ain=1.
- T2: Rout=1000, Gin=1, AddSub=0.
- T3: Gout=1, Rin=0010, Done=1.
REQ-039 SUB R2,R0, with Go held high and Instr changed during T1..T3 -> AddSub=1 in T2, and the sequence is unaffected. After Done, the block returns to IDLE for exactly one cycle with Go still high, accepts the new Instr, and enters T1 on the following edge.
REQ-040 Instr=1111_00_00_00 -> one cycle with Done=1 and Illegal=1 and all enables 0; InstrCount increments.
REQ-041 Rstb=0 during T2 of an ADD -> the next cycle is IDLE, all outputs 0, InstrCount=0, and no Rin pulse or Done for the aborted ADD.
REQ-042 256 completed instructions from reset -> InstrCount=0. Throughout all scenarios, a checker asserts REQ-025 through REQ-027 every cycle.
